// File: rtl/xo_issue_queue_if.sv
// Decoder-to-issue-queue, issue-to-execute and writeback signal bundle for xo_issue_queue.
// XO_XER_SCOREBOARD_EN adds the XER[CA/OV] writeback strobe xerWb_i.
interface xo_issue_queue_if #(
  parameter int regWidth     = 5,
  parameter int xOpCodeWidth = 9
);
  logic                    enable_i;
  logic [regWidth-1:0]     reg1_i;
  logic [regWidth-1:0]     reg2_i;
  logic [regWidth-1:0]     reg3_i;
  logic [xOpCodeWidth-1:0] xOpCode_i;
  logic                    bit1_i;
  logic                    bit2_i;
  logic                    stall_o;
  logic                    overflow_o;
  logic                    valid_o;
  logic                    ready_i;
  logic [regWidth-1:0]     reg1_o;
  logic [regWidth-1:0]     reg2_o;
  logic [regWidth-1:0]     reg3_o;
  logic [xOpCodeWidth-1:0] xOpCode_o;
  logic                    bit1_o;
  logic                    bit2_o;
  logic                    wbEnable_i;
  logic [regWidth-1:0]     wbReg_i;
`ifdef XO_XER_SCOREBOARD_EN
  logic                    xerWb_i;
`endif

  modport master (
    input  enable_i, reg1_i, reg2_i, reg3_i, xOpCode_i, bit1_i, bit2_i,
    output stall_o, overflow_o,
    output valid_o, reg1_o, reg2_o, reg3_o, xOpCode_o, bit1_o, bit2_o,
    input  ready_i,
    input  wbEnable_i, wbReg_i
`ifdef XO_XER_SCOREBOARD_EN
    , input xerWb_i
`endif
  );

  modport slave (
    output enable_i, reg1_i, reg2_i, reg3_i, xOpCode_i, bit1_i, bit2_i,
    input  stall_o, overflow_o,
    input  valid_o, reg1_o, reg2_o, reg3_o, xOpCode_o, bit1_o, bit2_o,
    output ready_i,
    output wbEnable_i, wbReg_i
`ifdef XO_XER_SCOREBOARD_EN
    , output xerWb_i
`endif
  );
endinterface

// File: rtl/xo_issue_queue.sv
// In-order issue queue for decoded XO ops with a per-GPR busy scoreboard.
// Optional XER[CA/OV] hazard tracking is enabled with XO_XER_SCOREBOARD_EN.
module xo_issue_queue #(
  parameter int regWidth     = 5,
  parameter int xOpCodeWidth = 9,
  parameter int queueDepth   = 4
) (
  input logic clock_i,
  input logic reset_i,
  xo_issue_queue_if.master bus
);
  localparam int PtrW   = $clog2(queueDepth);
  localparam int CntW   = PtrW + 1;
  localparam int EntryW = 3 * regWidth + xOpCodeWidth + 2;
  localparam int NumGpr = 2 ** regWidth;

  function automatic logic rb_used(input logic [xOpCodeWidth-1:0] xop);
    return !(xop == xOpCodeWidth'(104) || xop == xOpCodeWidth'(200) ||
             xop == xOpCodeWidth'(202) || xop == xOpCodeWidth'(232) ||
             xop == xOpCodeWidth'(234));
  endfunction

`ifdef XO_XER_SCOREBOARD_EN
  function automatic logic ca_reader(input logic [xOpCodeWidth-1:0] xop);
    return xop == xOpCodeWidth'(136) || xop == xOpCodeWidth'(138) ||
           xop == xOpCodeWidth'(200) || xop == xOpCodeWidth'(202) ||
           xop == xOpCodeWidth'(232) || xop == xOpCodeWidth'(234);
  endfunction

  function automatic logic ca_writer(input logic [xOpCodeWidth-1:0] xop);
    return ca_reader(xop) || xop == xOpCodeWidth'(8) || xop == xOpCodeWidth'(10);
  endfunction
`endif

  logic [EntryW-1:0]       mem_p0 [queueDepth];
  logic [PtrW-1:0]         wr_ptr;
  logic [PtrW-1:0]         rd_ptr;
  logic [CntW-1:0]         count;
  logic [NumGpr-1:0]       busy;
  logic [NumGpr-1:0]       busy_next;
  logic                    overflow;

  logic [regWidth-1:0]     head_rt;
  logic [regWidth-1:0]     head_ra;
  logic [regWidth-1:0]     head_rb;
  logic [xOpCodeWidth-1:0] head_xop;
  logic                    head_oe;
  logic                    head_rc;
  logic                    head_gpr_free;
  logic                    head_xer_free;
  logic                    eligible;
  logic                    deq;
  logic                    room;
  logic                    enq;

  logic                    vld_p1;
  logic [regWidth-1:0]     rt_p1;
  logic [regWidth-1:0]     ra_p1;
  logic [regWidth-1:0]     rb_p1;
  logic [xOpCodeWidth-1:0] xop_p1;
  logic                    oe_p1;
  logic                    rc_p1;

  assign {head_rt, head_ra, head_rb, head_xop, head_oe, head_rc} = mem_p0[rd_ptr];

  assign head_gpr_free = !busy[head_rt] && !busy[head_ra] &&
                         (!rb_used(head_xop) || !busy[head_rb]);

`ifdef XO_XER_SCOREBOARD_EN
  logic xer_busy;
  assign head_xer_free = !(xer_busy && (ca_reader(head_xop) || head_oe));
`else
  assign head_xer_free = 1'b1;
`endif

  assign eligible = (count != '0) && head_gpr_free && head_xer_free;
  assign deq      = eligible && (!vld_p1 || bus.ready_i);
  // A full queue still accepts when the head leaves on the same edge.
  assign room     = (count < CntW'(queueDepth)) || deq;
  assign enq      = bus.enable_i && room;

  always_comb begin
    busy_next = busy;
    if (bus.wbEnable_i) busy_next[bus.wbReg_i] = 1'b0;
    if (deq)            busy_next[head_rt]     = 1'b1;
  end

  // Stage p0: FIFO storage, written at the tail
  always_ff @(posedge clock_i) begin
    if (enq)
      mem_p0[wr_ptr] <= {bus.reg1_i, bus.reg2_i, bus.reg3_i, bus.xOpCode_i, bus.bit1_i, bus.bit2_i};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      busy     <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.enable_i && !room) overflow <= 1'b1;
      busy <= busy_next;
    end
  end

`ifdef XO_XER_SCOREBOARD_EN
  always_ff @(posedge clock_i) begin
    if (reset_i)
      xer_busy <= 1'b0;
    else if (deq && (ca_writer(head_xop) || head_oe))
      xer_busy <= 1'b1;
    else if (bus.xerWb_i)
      xer_busy <= 1'b0;
  end
`endif

  // Stage p1: issue register toward the execution stage
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      vld_p1 <= 1'b0;
      rt_p1  <= '0;
      ra_p1  <= '0;
      rb_p1  <= '0;
      xop_p1 <= '0;
      oe_p1  <= 1'b0;
      rc_p1  <= 1'b0;
    end else if (deq) begin
      vld_p1 <= 1'b1;
      rt_p1  <= head_rt;
      ra_p1  <= head_ra;
      rb_p1  <= head_rb;
      xop_p1 <= head_xop;
      oe_p1  <= head_oe;
      rc_p1  <= head_rc;
    end else if (vld_p1 && bus.ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.stall_o    = (count >= CntW'(queueDepth - 1));
  assign bus.overflow_o = overflow;
  assign bus.valid_o    = vld_p1;
  assign bus.reg1_o     = rt_p1;
  assign bus.reg2_o     = ra_p1;
  assign bus.reg3_o     = rb_p1;
  assign bus.xOpCode_o  = xop_p1;
  assign bus.bit1_o     = oe_p1;
  assign bus.bit2_o     = rc_p1;
endmodule

// File: tb/tb_xo_issue_queue.sv
// Scoreboard bench for xo_issue_queue: expected issues are queued at drive time
// and compared on each valid/ready handshake.
module tb_xo_issue_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q [$];

  xo_issue_queue_if #(.regWidth(5), .xOpCodeWidth(9)) bus ();

  xo_issue_queue #(.regWidth(5), .xOpCodeWidth(9), .queueDepth(4)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [4:0] rt, ra, rb, input logic [8:0] xop,
                                       input logic oe, rc);
    return {6'b0, rt, ra, rb, xop, oe, rc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] rt, ra, rb, input logic [8:0] xop, input logic oe,
                      input logic rc, input bit will_issue);
    bus.enable_i  = 1'b1;
    bus.reg1_i    = rt;
    bus.reg2_i    = ra;
    bus.reg3_i    = rb;
    bus.xOpCode_i = xop;
    bus.bit1_i    = oe;
    bus.bit2_i    = rc;
    if (will_issue) exp_q.push_back(pack(rt, ra, rb, xop, oe, rc));
    tick();
    bus.enable_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      tick();
      budget++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) begin
      check_eq("issue_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        check_eq("issue_fields",
                 pack(bus.reg1_o, bus.reg2_o, bus.reg3_o, bus.xOpCode_o, bus.bit1_o, bus.bit2_o),
                 exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit stall_tab [6];
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.enable_i = 1'b0; bus.reg1_i = '0; bus.reg2_i = '0; bus.reg3_i = '0;
    bus.xOpCode_i = '0; bus.bit1_i = 1'b0; bus.bit2_i = 1'b0;
    bus.ready_i = 1'b0; bus.wbEnable_i = 1'b0; bus.wbReg_i = '0;
`ifdef XO_XER_SCOREBOARD_EN
    bus.xerWb_i = 1'b0;
`endif
    tick();
    tick();
    check_eq("rst_valid", bus.valid_o, 0);
    check_eq("rst_stall", bus.stall_o, 0);
    check_eq("rst_overflow", bus.overflow_o, 0);
    check_eq("rst_reg1", bus.reg1_o, 0);
    check_eq("rst_xop", bus.xOpCode_o, 0);
    rst = 1'b0;

    // add latency into an empty queue
    bus.ready_i = 1'b1;
    send(5'd3, 5'd1, 5'd2, 9'd266, 1'b0, 1'b0, 1);
    check_eq("lat_edge0_valid", bus.valid_o, 0);
    tick();
    check_eq("lat_edge1_valid", bus.valid_o, 1);
    check_eq("lat_reg1", bus.reg1_o, 3);
    check_eq("lat_xop", bus.xOpCode_o, 266);
    tick();
    check_eq("lat_valid_drop", bus.valid_o, 0);

    // RAW dependency through busy[3], released by writeback
    do_reset();
    send(5'd3, 5'd1, 5'd2, 9'd266, 1'b0, 1'b0, 1);
    send(5'd4, 5'd3, 5'd5, 9'd40, 1'b1, 1'b1, 1);
    repeat (3) tick();
    check_eq("subf_held", bus.valid_o, 0);
    bus.wbEnable_i = 1'b1;
    bus.wbReg_i    = 5'd3;
    tick();
    bus.wbEnable_i = 1'b0;
    check_eq("subf_no_bypass", bus.valid_o, 0);
    tick();
    check_eq("subf_issue_valid", bus.valid_o, 1);
    check_eq("subf_issue_rt", bus.reg1_o, 4);
    drain("subf_drain");

    // overflow and stall with the execution stage blocked
    do_reset();
    bus.ready_i = 1'b0;
    stall_tab = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      send(5'(10 + i), 5'(20 + i), 5'd0, 9'd266, 1'b0, 1'(i & 1), i < 5);
      check_eq($sformatf("stall_after_op%0d", i), bus.stall_o, 32'(stall_tab[i]));
      check_eq($sformatf("overflow_after_op%0d", i), bus.overflow_o, (i == 5) ? 1 : 0);
    end
    check_eq("blocked_valid", bus.valid_o, 1);
    check_eq("blocked_head_rt", bus.reg1_o, 10);
    bus.ready_i = 1'b1;
    drain("overflow_drain");
    check_eq("overflow_sticky", bus.overflow_o, 1);
    check_eq("overflow_stall_clear", bus.stall_o, 0);

    // RB ignored for neg, honoured for add
    do_reset();
    send(5'd3, 5'd1, 5'd2, 9'd266, 1'b0, 1'b0, 1);
    repeat (2) tick();
    send(5'd6, 5'd7, 5'd3, 9'd104, 1'b0, 1'b0, 1);
    drain("neg_issues");
    send(5'd8, 5'd7, 5'd3, 9'd266, 1'b0, 1'b0, 0);
    repeat (4) tick();
    check_eq("add_rb_blocked", bus.valid_o, 0);

    // reset with queued and issued ops
    do_reset();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(5'(16 + i), 5'(24 + i), 5'd0, 9'd266, 1'b0, 1'b0, 1);
    check_eq("pre_rst_valid", bus.valid_o, 1);
    check_eq("pre_rst_stall", bus.stall_o, 1);
    do_reset();
    check_eq("mid_rst_valid", bus.valid_o, 0);
    check_eq("mid_rst_stall", bus.stall_o, 0);
    check_eq("mid_rst_reg1", bus.reg1_o, 0);
    bus.ready_i = 1'b1;
    send(5'd20, 5'd16, 5'd17, 9'd266, 1'b0, 1'b0, 1);
    check_eq("post_rst_latency0", bus.valid_o, 0);
    tick();
    check_eq("post_rst_busy_clear", bus.valid_o, 1);
    drain("post_rst_drain");
    repeat (4) tick();
    check_eq("post_rst_no_stale", bus.valid_o, 0);

`ifdef XO_XER_SCOREBOARD_EN
    // carry hazard: adde waits for the XER writeback after addc
    do_reset();
    bus.ready_i = 1'b1;
    send(5'd10, 5'd11, 5'd12, 9'd10, 1'b0, 1'b0, 1);
    send(5'd13, 5'd14, 5'd15, 9'd138, 1'b0, 1'b0, 1);
    repeat (3) tick();
    check_eq("adde_held", bus.valid_o, 0);
    bus.xerWb_i = 1'b1;
    tick();
    bus.xerWb_i = 1'b0;
    check_eq("adde_no_bypass", bus.valid_o, 0);
    tick();
    check_eq("adde_issue_valid", bus.valid_o, 1);
    check_eq("adde_issue_rt", bus.reg1_o, 13);
    drain("adde_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
